// File: rtl/hh_spike_detector.sv
// Spike detector for membrane-potential samples: threshold crossing with hysteresis,
// refractory window, saturating spike count and an FWFT FIFO of inter-spike intervals.
module hh_spike_detector #(
   parameter int DATA_W     = 16,
   parameter int ISI_W      = 16,
   parameter int REFRACT    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              v_valid,
   input  logic [DATA_W-1:0] v_data,
   input  logic [DATA_W-1:0] threshold,
   input  logic [7:0]        hyst,
   output logic              spike,
   output logic [15:0]       spike_count,
   output logic              isi_valid,
   output logic [ISI_W-1:0]  isi_data,
   input  logic              isi_ready,
   output logic              overflow
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int RC_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
   localparam logic [ISI_W-1:0] ISI_MAX = '1;
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {ARMED, ABOVE, REFRACTORY} state_t;
   state_t state, state_nx;

   logic signed [DATA_W:0] v_ext, thr_ext, hyst_ext, rearm;
   logic                   ge_thr, lt_rearm;
   logic                   spike_hit, rc_load, rc_dec;
   logic [RC_W-1:0]        refract_cnt;
   logic [ISI_W-1:0]       isi_cnt, isi_next;
   logic                   have_prev;

   logic [ISI_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             full, push_req, pop, do_push;

   // One extra bit of headroom so threshold - hyst cannot wrap.
   assign v_ext    = {v_data[DATA_W-1], v_data};
   assign thr_ext  = {threshold[DATA_W-1], threshold};
   assign hyst_ext = {{(DATA_W - 7){1'b0}}, hyst};
   assign rearm    = thr_ext - hyst_ext;
   assign ge_thr   = v_ext >= thr_ext;
   assign lt_rearm = v_ext < rearm;

   always_ff @(posedge clk) begin
      if (reset) state <= ARMED;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (v_valid) begin
         unique case (state)
            ARMED:      if (ge_thr) state_nx = ABOVE;
            ABOVE:      if (lt_rearm) state_nx = (REFRACT == 0) ? ARMED : REFRACTORY;
            REFRACTORY: if (refract_cnt == RC_W'(1)) state_nx = ARMED;
            default:    state_nx = ARMED;
         endcase
      end
   end

   always_comb begin
      spike_hit = v_valid && (state == ARMED) && ge_thr;
      rc_load   = v_valid && (state == ABOVE) && lt_rearm;
      rc_dec    = v_valid && (state == REFRACTORY);
   end

   assign isi_next = (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + ISI_W'(1);
   assign full     = (count == DEPTH_C);
   assign isi_valid = (count != '0);
   assign isi_data  = isi_valid ? mem[rd_ptr] : '0;
   assign pop       = isi_valid && isi_ready;
   assign push_req  = spike_hit && have_prev;
   assign do_push   = push_req && (!full || pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         spike       <= 1'b0;
         spike_count <= '0;
         refract_cnt <= '0;
         isi_cnt     <= '0;
         have_prev   <= 1'b0;
      end else begin
         spike <= spike_hit;
         if (spike_hit && spike_count != '1) spike_count <= spike_count + 16'd1;
         if (rc_load)     refract_cnt <= RC_W'(REFRACT);
         else if (rc_dec) refract_cnt <= refract_cnt - RC_W'(1);
         if (spike_hit) begin
            isi_cnt   <= '0;
            have_prev <= 1'b1;
         end else if (v_valid) begin
            isi_cnt <= isi_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= isi_next;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_req && !do_push) overflow <= 1'b1;
         unique case ({do_push, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule
